seg_capture: RTL and testbench

Receiving end of the seven-segment interface: samples the active-high segment lines A–G and Dp driven by the hex-to-segment decoder, waits until a pattern has held stable for a programmable number of clocks, and converts it back to a 4-bit hex digit. Each newly stabilised pattern is delivered once over a valid/ready handshake, with an error flag for patterns outside the hex glyph set. Used as a loopback checker behind the display decoder and as a segment-bus monitor in board-level tests.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_glyph_lookup.sv | 19 +
 rtl/seg_capture.sv | 76 +++++++
 tb/tb_seg_capture.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: seven-segment glyph constants (bit order A..G) and the capture state type,
// shared by the display decoder, seg_capture and their benches.
package seg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;
  localparam logic [15:0][6:0] SEG_GLYPHS = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                             SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
  typedef enum logic {EMPTY, FULL} seg_state_t;
endpackage

// File: rtl/seg_glyph_lookup.sv
// seg_glyph_lookup: inverse of the display decoder, maps an A..G pattern to its hex digit;
// err flags patterns outside the glyph set (digit is 0 then).
module seg_glyph_lookup
  import seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] digit,
  output logic       err
);
  always_comb begin
    digit = '0;
    err = 1'b1;
    for (int i = 0; i < 16; i++)
      if (pat == SEG_GLYPHS[i]) begin
        digit = 4'(i);
        err = 1'b0;
      end
  end
endmodule

// File: rtl/seg_capture.sv
// seg_capture: waits for a segment pattern to hold STABLE_CYCLES clocks, decodes it once to hex
// and offers it over valid/ready. SEG_CAPTURE_DP_EN: Dp joins the stability/dedup compare and drives dp.
module seg_capture
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       E,
  input  logic       F,
  input  logic       G,
  input  logic       Dp,
  input  logic       ready,
  output logic [3:0] digit,
  output logic       dp,
  output logic       err,
  output logic       valid,
  output logic       overrun
);
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_cfg
    $error("seg_capture: STABLE_CYCLES must be within 1..255");
  end
  localparam logic [7:0] SAT_CNT = 8'(STABLE_CYCLES);
  localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);
  logic [7:0] in_v, s, last, cnt;
  logic [3:0] lk_digit;
  logic lk_err, accept, load;
  seg_state_t state;
`ifdef SEG_CAPTURE_DP_EN
  assign in_v = {A, B, C, D, E, F, G, Dp};
`else
  logic unused_dp;
  assign unused_dp = Dp;
  assign in_v = {A, B, C, D, E, F, G, 1'b0};
`endif
  // accept on the edge where cnt would step from STABLE_CYCLES-1 to STABLE_CYCLES
  assign accept = (in_v == s) && (cnt == LAST_CNT) && (s != last);
  assign load = accept && (s[7:1] != SEG_BLANK);
  seg_glyph_lookup u_lookup (.pat(s[7:1]), .digit(lk_digit), .err(lk_err));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s <= '0;
      cnt <= '0;
      last <= {SEG_BLANK, 1'b0};
    end else begin
      s <= in_v;
      cnt <= (in_v != s) ? 8'd0 : (cnt == SAT_CNT) ? cnt : cnt + 8'd1;
      if (accept) last <= s;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      digit <= '0;
      dp <= 1'b0;
      err <= 1'b0;
      valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= load && state == FULL && !ready;
      if (load && (state == EMPTY || ready)) begin
        state <= FULL;
        valid <= 1'b1;
        digit <= lk_digit;
        dp <= s[0];
        err <= lk_err;
      end else if (state == FULL && ready) begin
        state <= EMPTY;
        valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: directed scenarios plus randomized patterns checked against a run-length model.
module tb_seg_capture;
  localparam int SC = 4;
`ifdef SEG_CAPTURE_DP_EN
  localparam bit DPEN = 1'b1;
`else
  localparam bit DPEN = 1'b0;
`endif
  localparam logic [6:0] GLY [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  logic clk = 1'b0, rst_n = 1'b0;
  logic A = 0, B = 0, C = 0, D = 0, E = 0, F = 0, G = 0, Dp = 0, ready = 0;
  logic [3:0] digit;
  logic dp, err, valid, overrun;
  int checks = 0, errors = 0, ovr_cnt = 0;
  logic [5:0] xq [$];
  logic [7:0] m_vec, m_last;
  int m_run;
  bit m_full, m_ovr;
  logic [3:0] m_dig;
  logic m_dp, m_err;

  seg_capture #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .Dp(Dp),
    .ready(ready), .digit(digit), .dp(dp), .err(err), .valid(valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic int glyph_of(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (GLY[i] == p) return i;
    return -1;
  endfunction

  // a pattern is accepted once it has been sampled SC+1 times in a row (reset s counts as a blank sample)
  task automatic model_edge(input logic [7:0] v, input logic r);
    bit acc;
    int g;
    if (v == m_vec) m_run++;
    else begin
      m_vec = v;
      m_run = 1;
    end
    acc = (m_run == SC + 1) && (m_vec != m_last);
    if (acc) m_last = m_vec;
    m_ovr = 0;
    if (m_full && r) m_full = 0;
    if (acc && m_vec[7:1] != 7'd0) begin
      if (m_full) m_ovr = 1;
      else begin
        g = glyph_of(m_vec[7:1]);
        m_full = 1;
        m_err = g < 0;
        m_dig = g < 0 ? 4'd0 : 4'(g);
        m_dp = m_vec[0];
      end
    end
  endtask

  task automatic model_reset();
    m_vec = '0; m_last = '0; m_run = 1; m_full = 0; m_ovr = 0;
    m_dig = '0; m_dp = 0; m_err = 0;
  endtask

  task automatic step(input logic [6:0] p, input logic d, input logic r);
    {A, B, C, D, E, F, G} = p;
    Dp = d;
    ready = r;
    #1;
    if (valid && ready) xq.push_back({digit, dp, err});
    @(posedge clk);
    model_edge({p, DPEN ? d : 1'b0}, r);
    @(negedge clk);
    if (overrun) ovr_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    xq.delete();
    ovr_cnt = 0;
  endtask

  task automatic test_reset();
    {A, B, C, D, E, F, G, Dp} = 8'($urandom);
    ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({digit, dp, err, valid, overrun} !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 00000000", {digit, dp, err, valid, overrun});
    end
    do_reset();
    repeat (3) step(7'd0, 1'b0, 1'b1);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_valid got %b exp 0", valid);
    end
  endtask

  task automatic test_latency();
    logic [5:0] vm;
    xq.delete();
    for (int i = 0; i < 6; i++) begin
      step(GLY[0], 1'b0, 1'b1);
      vm[i] = valid;
    end
    checks++;
    if (vm !== 6'b010000) begin
      errors++;
      $display("FAIL latency_mask got %b exp 010000", vm);
    end
    checks++;
    if (xq.size() != 1 || xq[0] !== 6'b000000) begin
      errors++;
      $display("FAIL latency_result got n=%0d first=%b exp n=1 000000", xq.size(), xq.size() ? xq[0] : 6'bx);
    end
  endtask

  task automatic test_glitch();
    xq.delete();
    repeat (3) step(GLY[1], 1'b0, 1'b1);
    repeat (5) step(GLY[8], 1'b0, 1'b1);
    repeat (2) step(7'd0, 1'b0, 1'b1);
    checks++;
    if (xq.size() != 1 || xq[0] !== {4'h8, 2'b00}) begin
      errors++;
      $display("FAIL glitch_result got n=%0d first=%b exp n=1 100000", xq.size(), xq.size() ? xq[0] : 6'bx);
    end
  endtask

  task automatic test_hold_once();
    xq.delete();
    repeat (20) step(GLY[5], 1'b0, 1'b1);
    checks++;
    if (xq.size() != 1 || xq[0] !== {4'h5, 2'b00}) begin
      errors++;
      $display("FAIL hold_once got n=%0d exp n=1 digit 5", xq.size());
    end
    repeat (5) step(7'd0, 1'b0, 1'b1);
    repeat (6) step(GLY[5], 1'b0, 1'b1);
    checks++;
    if (xq.size() != 2 || xq[xq.size() - 1] !== {4'h5, 2'b00}) begin
      errors++;
      $display("FAIL hold_reemit got n=%0d exp n=2 digit 5", xq.size());
    end
  endtask

  task automatic test_illegal();
    xq.delete();
    repeat (6) step(7'b1000001, 1'b0, 1'b1);
    checks++;
    if (xq.size() != 1 || xq[0] !== 6'b000001) begin
      errors++;
      $display("FAIL illegal_result got n=%0d first=%b exp n=1 000001", xq.size(), xq.size() ? xq[0] : 6'bx);
    end
  endtask

  task automatic test_overrun();
    xq.delete();
    ovr_cnt = 0;
    repeat (5) step(GLY[3], 1'b0, 1'b0);
    repeat (5) step(GLY[7], 1'b0, 1'b0);
    checks++;
    if (ovr_cnt != 1) begin
      errors++;
      $display("FAIL overrun_pulses got %0d exp 1", ovr_cnt);
    end
    checks++;
    if (valid !== 1'b1 || digit !== 4'h3) begin
      errors++;
      $display("FAIL overrun_held got valid=%b digit=%h exp valid=1 digit=3", valid, digit);
    end
    step(GLY[7], 1'b0, 1'b1);
    checks++;
    if (xq.size() != 1 || xq[0] !== {4'h3, 2'b00} || valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_drain got n=%0d valid=%b exp n=1 digit 3 valid=0", xq.size(), valid);
    end
  endtask

  task automatic test_dp_reset();
    xq.delete();
    repeat (6) step(GLY[9], 1'b0, 1'b1);
    repeat (6) step(GLY[9], 1'b1, 1'b1);
    checks++;
    if (xq.size() != (DPEN ? 2 : 1) || xq[0] !== {4'h9, 2'b00}) begin
      errors++;
      $display("FAIL dp_emits got n=%0d exp n=%0d", xq.size(), DPEN ? 2 : 1);
    end
    checks++;
    if (xq.size() != 0 && xq[xq.size() - 1] !== {4'h9, DPEN, 1'b0}) begin
      errors++;
      $display("FAIL dp_value got %b exp %b", xq[xq.size() - 1], {4'h9, DPEN, 1'b0});
    end
    repeat (5) step(7'd0, 1'b0, 1'b0);
    repeat (5) step(GLY[9], 1'b1, 1'b0);
    checks++;
    if (valid !== 1'b1 || digit !== 4'h9 || dp !== DPEN) begin
      errors++;
      $display("FAIL dp_hold got valid=%b digit=%h dp=%b exp 1 9 %b", valid, digit, dp, DPEN);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({digit, dp, err, valid, overrun} !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got %b exp 00000000", {digit, dp, err, valid, overrun});
    end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_random();
    logic [6:0] p;
    logic d;
    int sel, len;
    do_reset();
    p = 7'd0;
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6) p = GLY[$urandom_range(0, 15)];
      else if (sel < 8) p = 7'd0;
      else if (sel == 8) p = 7'($urandom);
      d = 1'($urandom_range(0, 1));
      len = $urandom_range(1, SC + 3);
      for (int k = 0; k < len; k++) begin
        step(p, (k == len - 1 && $urandom_range(0, 3) == 0) ? ~d : d, $urandom_range(0, 3) != 0);
        checks++;
        if (valid !== m_full || overrun !== m_ovr) begin
          errors++;
          $display("FAIL rnd_flags got valid=%b overrun=%b exp %b %b", valid, overrun, m_full, m_ovr);
        end
        if (m_full) begin
          checks++;
          if ({digit, dp, err} !== {m_dig, m_dp, m_err}) begin
            errors++;
            $display("FAIL rnd_result got %b exp %b", {digit, dp, err}, {m_dig, m_dp, m_err});
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_glitch();
    test_hold_once();
    test_illegal();
    test_overrun();
    test_dp_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
